// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with iterative Booth multiply and restoring divide
// Build macro SEQ_ALU_RADIX4_EN switches the multiplier to radix-4 Booth (WIDTH/2 steps).
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] C,
    output logic               busy,
    output logic               done,
    output logic               div_zero
);
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_NOR  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

`ifdef SEQ_ALU_RADIX4_EN
    localparam int BOOTH_BITS = 2;
`else
    localparam int BOOTH_BITS = 1;
`endif
    localparam int MUL_STEPS = WIDTH / BOOTH_BITS;
    localparam int CW        = $clog2(WIDTH);
    localparam int PW        = 2*WIDTH + 3;
    localparam logic [SHW:0] ROT_MOD = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;
    state_t state, state_next;

    logic [4:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic [CW-1:0]    count;
    // Booth register: {accumulator (W+2), multiplier (W), appended q[-1]}
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] quo, rem, dmag;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL || (opcode == OP_DIV && B != '0))
                        state_next = ITER;
                    else
                        state_next = FINISH;
                end
            end
            ITER:    if (count == '0) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == ITER);

    logic signed [WIDTH+1:0] m1, addend, acc_sum;
    logic signed [PW-1:0]    booth_cat;
    logic [PW-1:0]           prod_step;

    always_comb begin
        m1     = {{2{a_r[WIDTH-1]}}, a_r};
        addend = '0;
`ifdef SEQ_ALU_RADIX4_EN
        case (prod[2:0])
            3'b001, 3'b010: addend = m1;
            3'b011:         addend = m1 <<< 1;
            3'b100:         addend = -(m1 <<< 1);
            3'b101, 3'b110: addend = -m1;
            default:        addend = '0;
        endcase
`else
        case (prod[1:0])
            2'b01:   addend = m1;
            2'b10:   addend = -m1;
            default: addend = '0;
        endcase
`endif
        acc_sum   = $signed(prod[PW-1:WIDTH+1]) + addend;
        booth_cat = {acc_sum, prod[WIDTH:0]};
        prod_step = booth_cat >>> BOOTH_BITS;
    end

    logic [WIDTH:0]   r2;
    logic             ge;
    logic [WIDTH-1:0] rem_next, quo_next;

    always_comb begin
        r2       = {rem, quo[WIDTH-1]};
        ge       = (r2 >= {1'b0, dmag});
        rem_next = ge ? WIDTH'(r2 - {1'b0, dmag}) : r2[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ge};
    end

    logic [SHW-1:0]     sh;
    logic [SHW:0]       rot;
    logic [2*WIDTH-1:0] dbl, result;
    logic [WIDTH-1:0]   lo, q_s, r_s;

    always_comb begin
        sh     = b_r[SHW-1:0];
        rot    = ({1'b0, sh} >= ROT_MOD) ? ({1'b0, sh} - ROT_MOD) : {1'b0, sh};
        dbl    = {a_r, a_r};
        q_s    = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? -quo : quo;
        r_s    = a_r[WIDTH-1] ? -rem : rem;
        lo     = '0;
        result = C;
        case (op_r)
            OP_ADD: begin
                lo     = a_r + b_r;
                result = {{WIDTH{lo[WIDTH-1]}}, lo};
            end
            OP_SUB: begin
                lo     = a_r - b_r;
                result = {{WIDTH{lo[WIDTH-1]}}, lo};
            end
            OP_AND:  result = {{WIDTH{1'b0}}, a_r & b_r};
            OP_OR:   result = {{WIDTH{1'b0}}, a_r | b_r};
            OP_XOR:  result = {{WIDTH{1'b0}}, a_r ^ b_r};
            OP_NOR:  result = {{WIDTH{1'b0}}, ~(a_r | b_r)};
            OP_ROR:  result = {{WIDTH{1'b0}}, WIDTH'(dbl >> rot)};
            OP_ROL:  result = {{WIDTH{1'b0}}, WIDTH'((dbl << rot) >> WIDTH)};
            OP_SHR:  result = {{WIDTH{1'b0}}, a_r >> sh};
            OP_SHRA: result = {{WIDTH{1'b0}}, WIDTH'($signed(a_r) >>> sh)};
            OP_SHL:  result = {{WIDTH{1'b0}}, a_r << sh};
            OP_NEG:  result = {{WIDTH{1'b0}}, -b_r};
            OP_NOT:  result = {{WIDTH{1'b0}}, ~a_r};
            OP_MUL:  result = prod[2*WIDTH:1];
            // Divide-by-zero bypasses iteration and returns the dividend in HI
            OP_DIV:  result = (b_r == '0) ? {a_r, {WIDTH{1'b1}}} : {r_s, q_s};
            default: result = C;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            C        <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            count    <= '0;
            prod     <= '0;
            quo      <= '0;
            rem      <= '0;
            dmag     <= '0;
        end else begin
            state <= state_next;
            done  <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r     <= opcode;
                        a_r      <= A;
                        b_r      <= B;
                        div_zero <= (opcode == OP_DIV) && (B == '0);
                        count    <= (opcode == OP_MUL) ? CW'(MUL_STEPS - 1) : CW'(WIDTH - 1);
                        prod     <= {{(WIDTH+2){1'b0}}, B, 1'b0};
                        quo      <= A[WIDTH-1] ? -A : A;
                        rem      <= '0;
                        dmag     <= B[WIDTH-1] ? -B : B;
                    end
                end
                ITER: begin
                    count <= count - CW'(1);
                    if (op_r == OP_MUL) begin
                        prod <= prod_step;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                    end
                end
                FINISH:  C <= result;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (WIDTH=32)
module tb_seq_alu;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_NOR  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
`ifdef SEQ_ALU_RADIX4_EN
    localparam int MUL_LAT = 17;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam logic [4:0] OPS [18] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
        OP_SHR, OP_SHRA, OP_SHL, OP_XOR, OP_NOR, OP_DIV, OP_MUL, OP_NEG, OP_NOT, OP_NOP,
        5'b11111, 5'b00000};

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  opcode = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [63:0] C;
    logic        busy, done, div_zero;

    seq_alu #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear), .start(start), .opcode(opcode),
        .A(A), .B(B), .C(C), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [63:0] model_c = '0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] c;
        int          lat;
        logic        dz;
    } vec_t;
    vec_t vecs[$];

    function automatic void check(input bit ok, input string name,
                                  input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference computed from the arithmetic meaning of each operation
    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] prev);
        int n;
        logic [31:0] r;
        int qi, ri;
        longint p;
        n = int'(b[4:0]) % 32;
        r = a;
        case (op)
            OP_ADD:  begin r = a + b; return {{32{r[31]}}, r}; end
            OP_SUB:  begin r = a - b; return {{32{r[31]}}, r}; end
            OP_AND:  return {32'h0, a & b};
            OP_OR:   return {32'h0, a | b};
            OP_XOR:  return {32'h0, a ^ b};
            OP_NOR:  return {32'h0, ~(a | b)};
            OP_ROR:  begin repeat (n) r = {r[0], r[31:1]}; return {32'h0, r}; end
            OP_ROL:  begin repeat (n) r = {r[30:0], r[31]}; return {32'h0, r}; end
            OP_SHR:  return {32'h0, a >> n};
            OP_SHRA: begin r = $signed(a) >>> n; return {32'h0, r}; end
            OP_SHL:  return {32'h0, a << n};
            OP_NEG:  return {32'h0, -b};
            OP_NOT:  return {32'h0, ~a};
            OP_MUL:  begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
            OP_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                qi = $signed(a) / $signed(b);
                ri = $signed(a) % $signed(b);
                return {32'(ri), 32'(qi)};
            end
            default: return prev;
        endcase
    endfunction

    task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] c, input int lat, input logic dz);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c; v.lat = lat; v.dz = dz;
        vecs.push_back(v);
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_c, input int exp_lat, input logic exp_dz,
                          input string name);
        int lat;
        bit got, both;
        @(negedge clock);
        opcode = op; A = a; B = b; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check(busy == (exp_lat > 1), {name, "_busy"}, 64'(busy), 64'(exp_lat > 1));
        lat = 0; got = 0; both = 0;
        for (int k = 1; k <= 80 && !got; k++) begin
            @(posedge clock);
            #1;
            if (busy && done) both = 1;
            if (done) begin got = 1; lat = k; end
        end
        check(got && lat == exp_lat, {name, "_latency"}, 64'(lat), 64'(exp_lat));
        check(!both, {name, "_busy_done_overlap"}, 64'(both), 64'(0));
        check(C === exp_c, {name, "_C"}, C, exp_c);
        check(div_zero === exp_dz, {name, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
        @(posedge clock);
        #1;
        check(done == 1'b0, {name, "_done_pulse"}, 64'(done), 64'(0));
        model_c = exp_c;
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp_c, cap;
        int lat, ndone;
        bit got;

        repeat (3) @(posedge clock);
        #1;
        check(C === 64'h0, "reset_C", C, 64'h0);
        check(busy === 1'b0, "reset_busy", 64'(busy), 64'h0);
        check(done === 1'b0, "reset_done", 64'(done), 64'h0);
        check(div_zero === 1'b0, "reset_div_zero", 64'(div_zero), 64'h0);
        @(negedge clock);
        clear = 1'b0;

        add_vec(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 64'hFFFFFFFF_80000000, 1, 1'b0);
        add_vec(OP_SUB,  32'h00000005, 32'h00000007, 64'hFFFFFFFF_FFFFFFFE, 1, 1'b0);
        add_vec(OP_MUL,  32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, MUL_LAT, 1'b0);
        add_vec(OP_DIV,  32'hFFFFFFEF, 32'h00000005, 64'hFFFFFFFE_FFFFFFFD, DIV_LAT, 1'b0);
        add_vec(OP_DIV,  32'h00000009, 32'h00000000, 64'h00000009_FFFFFFFF, 1, 1'b1);
        add_vec(OP_ROR,  32'h80000001, 32'd33,       64'h00000000_C0000000, 1, 1'b0);
        add_vec(OP_SHRA, 32'h80000001, 32'd33,       64'h00000000_C0000000, 1, 1'b0);
        add_vec(OP_SHL,  32'h80000001, 32'd33,       64'h00000000_00000002, 1, 1'b0);
        add_vec(OP_SHR,  32'h80000001, 32'd33,       64'h00000000_40000000, 1, 1'b0);
        add_vec(OP_ROL,  32'h80000001, 32'd4,        64'h00000000_00000018, 1, 1'b0);
        add_vec(OP_ROL,  32'h12345678, 32'd32,       64'h00000000_12345678, 1, 1'b0);
        add_vec(OP_ROR,  32'h12345678, 32'd0,        64'h00000000_12345678, 1, 1'b0);
        add_vec(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, DIV_LAT, 1'b0);
        add_vec(OP_DIV,  32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, DIV_LAT, 1'b0);
        add_vec(OP_MUL,  32'h80000000, 32'h80000000, 64'h40000000_00000000, MUL_LAT, 1'b0);
        add_vec(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000, 1, 1'b0);
        add_vec(OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_FFF0FFF0, 1, 1'b0);
        add_vec(OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_0FF00FF0, 1, 1'b0);
        add_vec(OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_000F000F, 1, 1'b0);
        add_vec(OP_NEG,  32'h00000000, 32'h00000001, 64'h00000000_FFFFFFFF, 1, 1'b0);
        add_vec(OP_NOT,  32'h0000FFFF, 32'h00000000, 64'h00000000_FFFF0000, 1, 1'b0);
        add_vec(OP_NOP,  32'hDEADBEEF, 32'h12345678, 64'h00000000_FFFF0000, 1, 1'b0);
        add_vec(5'b11111, 32'h1,       32'h2,        64'h00000000_FFFF0000, 1, 1'b0);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].lat, vecs[i].dz,
                   $sformatf("vec%0d", i));

        // div_zero stays set after the result until the next accepted start
        run_op(OP_DIV, 32'h00000009, 32'h0, 64'h00000009_FFFFFFFF, 1, 1'b1, "div0_again");
        repeat (3) @(posedge clock);
        #1;
        check(div_zero === 1'b1, "div_zero_sticky", 64'(div_zero), 64'h1);

        // start during an in-flight mul is ignored
        @(negedge clock);
        opcode = OP_MUL; A = 32'hFFFFFFFD; B = 32'h7; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        opcode = OP_OR; A = 32'h0F0F0000; B = 32'h000000F0; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        ndone = 0; lat = 0; cap = '0;
        for (int k = 6; k <= MUL_LAT + 10; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                ndone++;
                if (lat == 0) begin lat = k; cap = C; end
            end
        end
        check(ndone == 1, "busy_start_done_count", 64'(ndone), 64'h1);
        check(lat == MUL_LAT, "busy_start_latency", 64'(lat), 64'(MUL_LAT));
        check(cap === 64'hFFFFFFFF_FFFFFFEB, "busy_start_C", cap, 64'hFFFFFFFF_FFFFFFEB);
        check(C === 64'hFFFFFFFF_FFFFFFEB, "busy_start_C_hold", C, 64'hFFFFFFFF_FFFFFFEB);

        // clear during iteration aborts with no done
        @(negedge clock);
        opcode = OP_MUL; A = 32'h12345678; B = 32'h9ABCDEF0; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (7) @(posedge clock);
        #1 clear = 1'b1;
        #1;
        check(C === 64'h0, "clear_mid_C", C, 64'h0);
        check(busy === 1'b0, "clear_mid_busy", 64'(busy), 64'h0);
        @(negedge clock);
        clear = 1'b0;
        got = 0;
        repeat (MUL_LAT + 5) begin
            @(posedge clock);
            #1;
            if (done) got = 1;
        end
        check(!got, "clear_mid_no_done", 64'(got), 64'h0);
        model_c = '0;
        run_op(OP_ADD, 32'd3, 32'd4, 64'h7, 1, 1'b0, "add_after_clear");

        for (int i = 0; i < 40; i++) begin
            op = OPS[$urandom_range(0, 17)];
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 4) == 0) b = $urandom_range(0, 33);
            exp_c = model(op, a, b, model_c);
            lat = (op == OP_MUL) ? MUL_LAT : ((op == OP_DIV && b != 0) ? DIV_LAT : 1);
            run_op(op, a, b, exp_c, lat, (op == OP_DIV && b == 0), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
